// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline flow controller: stage indices and
// the default geometry of the pipe and the fetch counters.
package pipe_ctrl_pkg;

    // Classic five-stage naming; stage 0 is fetch, the last stage is writeback.
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_CNT_W      = 2;

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline stage slot: a valid bit plus its allow-in and hand-off terms.
module pipe_stage_slot (
    input  logic clk,
    input  logic resetn,
    input  logic up_offer,    // upstream presents an item this cycle
    input  logic ready_go,    // this stage has finished its work
    input  logic allow_next,  // downstream can take an item this cycle
    input  logic flush,       // kill this stage's content
    output logic valid,
    output logic allow_in,
    output logic stage_go
);

    // An empty slot always accepts; a full one only when its item leaves.
    assign allow_in = !valid || (ready_go && allow_next);

    // A killed item must not leak downstream in the flush cycle.
    assign stage_go = valid && ready_go && allow_next && !flush;

    // Valid register: flush wins over load, otherwise load when allowed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (allow_in) begin
            valid <= up_offer;
        end
    end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// N-stage valid/allow-in chain with per-stage flush, plus outstanding
// fetch-request tracking that marks responses made stale by a stage-0 flush.
//
// Handshake between adjacent stages: an item moves from stage i to i+1 on a
// rising edge exactly when valid[i] && ready_go[i] && allow_in[i+1] and
// stage i is not being flushed (that is stage_go[i]); neither side may
// retract its term based on the other within the cycle. The last stage
// hands off to the sink under the same rule with out_allow in place of
// allow_in[i+1].
module pipe_flow_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [NUM_STAGES-1:0] ready_go,
    input  logic                  out_allow,
    input  logic [NUM_STAGES-1:0] flush_mask,
    input  logic                  req_issued,
    input  logic                  resp_valid,
    output logic [NUM_STAGES-1:0] valid,
    output logic [NUM_STAGES-1:0] allow_in,
    output logic [NUM_STAGES-1:0] stage_go,
    output logic                  req_allow,
    output logic                  resp_discard
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Each slot keeps its chain terms in its own generate scope so the
    // combinational allow-in chain is a set of scalar nets, not one vector
    // that feeds back into itself.
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
        logic up_offer;
        logic nxt_allow;
        logic slot_valid;
        logic slot_allow;
        logic slot_go;

        if (i == STG_IF) begin : g_head
            assign up_offer = in_valid;
        end else begin : g_body
            assign up_offer = g_slot[i-1].slot_go;
        end

        if (i == NUM_STAGES - 1) begin : g_tail
            assign nxt_allow = out_allow;
        end else begin : g_link
            assign nxt_allow = g_slot[i+1].slot_allow;
        end

        pipe_stage_slot u_slot (
            .clk        (clk),
            .resetn     (resetn),
            .up_offer   (up_offer),
            .ready_go   (ready_go[i]),
            .allow_next (nxt_allow),
            .flush      (flush_mask[i]),
            .valid      (slot_valid),
            .allow_in   (slot_allow),
            .stage_go   (slot_go)
        );

        assign valid[i]    = slot_valid;
        assign allow_in[i] = slot_allow;
        assign stage_go[i] = slot_go;
    end

    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] disc_cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // In-flight count after this edge; also what a flush marks as stale.
    assign cnt_nxt = out_cnt + CNT_W'(req_issued) - CNT_W'(resp_valid);

    // Outstanding-request counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_cnt <= '0;
        end else begin
            out_cnt <= cnt_nxt;
        end
    end

    // Stale-response counter: reloaded on a fetch flush, drained by responses.
    // A response in the flush cycle itself is killed by the stage-0 flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            disc_cnt <= '0;
        end else if (flush_mask[STG_IF]) begin
            disc_cnt <= cnt_nxt;
        end else if (resp_valid && (disc_cnt != '0)) begin
            disc_cnt <= disc_cnt - 1'b1;
        end
    end

    assign req_allow    = (out_cnt != CNT_MAX);
    assign resp_discard = resp_valid && (disc_cnt != '0) && !flush_mask[STG_IF];

    // Issuing past the in-flight limit would wrap the counter.
    a_req_in_limit : assert property (@(posedge clk) disable iff (!resetn)
        req_issued |-> req_allow);

endmodule
